// File: rtl/galaga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : galaga_pkg
// Purpose : Shared definitions for the collision event scheduler: event type
//           encoding, default sizing/gameplay constants and a saturating
//           score adder.
// Ports   : (package - none)
// Rev     : 1.0  initial release
// ============================================================================
package galaga_pkg;

  localparam int NUM_NPC_DEF     = 10;
  localparam int NUM_ROCKET_DEF  = 15;
  localparam int KILL_POINTS_DEF = 10;
  localparam int LIVES_INIT_DEF  = 3;

  typedef enum logic [2:0] {
    EVT_NPC_KILL    = 3'd0,
    EVT_SHIP1_HIT   = 3'd1,
    EVT_SHIP2_HIT   = 3'd2,
    EVT_ROCKET1_CLR = 3'd3,
    EVT_ROCKET2_CLR = 3'd4
  } evt_type_e;

  // 16-bit add that clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_set_idx.sv
`default_nettype none
// ============================================================================
// Module  : lowest_set_idx
// Purpose : Parameterised priority encoder returning the index of the lowest
//           set bit of a vector plus a nonzero flag.
// Ports   : vec_i  [W-1:0]      input vector
//           idx_o  [IDX_W-1:0]  index of lowest set bit (0 when vector empty)
//           any_o               vector has at least one bit set
// Rev     : 1.0  initial release
// ============================================================================
module lowest_set_idx #(
  parameter int W     = 10,
  parameter int IDX_W = 4
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walk from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule
`default_nettype wire

// File: rtl/collision_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : collision_event_scheduler
// Purpose : Snapshots latched collision flags on each frame strobe edge and
//           serialises them into a stream of game events (NPC kills, ship
//           hits, rocket clears) over a valid/ready handshake, maintaining
//           player scores and lives.
// Ports   : VGA_CLK, Reset_n           clock, async active-low reset
//           frame_clk                  frame strobe (rising edge sampled)
//           Ship_Collision(2)          ship-hit flags
//           Rocket_Collision(2)        rocket-hit vectors [NUM_ROCKET]
//           NPC_Collision              NPC-hit vector [NUM_NPC]
//           evt_valid/evt_ready        event handshake
//           evt_type[3], evt_index[4]  event payload
//           score1/2[16], lives1/2[2]  player state
//           busy, game_over, overrun   status
// Rev     : 1.0  initial release
// ============================================================================
module collision_event_scheduler
  import galaga_pkg::*;
#(
  parameter int NUM_NPC     = NUM_NPC_DEF,
  parameter int NUM_ROCKET  = NUM_ROCKET_DEF,
  parameter int LIVES_INIT  = LIVES_INIT_DEF,
  parameter int KILL_POINTS = KILL_POINTS_DEF
) (
  input  logic                  VGA_CLK,
  input  logic                  Reset_n,
  input  logic                  frame_clk,
  input  logic                  Ship_Collision,
  input  logic                  Ship_Collision2,
  input  logic [NUM_ROCKET-1:0] Rocket_Collision,
  input  logic [NUM_ROCKET-1:0] Rocket_Collision2,
  input  logic [NUM_NPC-1:0]    NPC_Collision,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [2:0]            evt_type,
  output logic [3:0]            evt_index,
  output logic [15:0]           score1,
  output logic [15:0]           score2,
  output logic [1:0]            lives1,
  output logic [1:0]            lives2,
  output logic                  busy,
  output logic                  game_over,
  output logic                  overrun
);

  // state_q tracks the category of the event currently presented (or the
  // phase about to be scanned right after a snapshot).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_NPC   = 3'd1;
  localparam logic [2:0] ST_SHIP1 = 3'd2;
  localparam logic [2:0] ST_SHIP2 = 3'd3;
  localparam logic [2:0] ST_RKT1  = 3'd4;
  localparam logic [2:0] ST_RKT2  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  frame_q;
  logic [NUM_NPC-1:0]    npc_q, npc_d;
  logic [NUM_ROCKET-1:0] rk1_q, rk1_d;
  logic [NUM_ROCKET-1:0] rk2_q, rk2_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic                  cr1_q, cr1_d;   // snapshot had a player-1 rocket hit
  logic                  cr2_q, cr2_d;   // snapshot had a player-2 rocket hit
  logic                  evt_valid_q, evt_valid_d;
  evt_type_e             evt_type_q, evt_type_d;
  logic [3:0]            evt_index_q, evt_index_d;
  logic [15:0]           score1_q, score1_d;
  logic [15:0]           score2_q, score2_d;
  logic [1:0]            lives1_q, lives1_d;
  logic [1:0]            lives2_q, lives2_d;
  logic                  overrun_q, overrun_d;

  logic [3:0] npc_idx, rk1_idx, rk2_idx;
  logic       npc_any, rk1_any, rk2_any;
  logic       frame_edge, snap_any, xfer, slot_free;

  lowest_set_idx #(.W(NUM_NPC), .IDX_W(4)) u_npc_enc (
    .vec_i (npc_q),
    .idx_o (npc_idx),
    .any_o (npc_any)
  );

  lowest_set_idx #(.W(NUM_ROCKET), .IDX_W(4)) u_rk1_enc (
    .vec_i (rk1_q),
    .idx_o (rk1_idx),
    .any_o (rk1_any)
  );

  lowest_set_idx #(.W(NUM_ROCKET), .IDX_W(4)) u_rk2_enc (
    .vec_i (rk2_q),
    .idx_o (rk2_idx),
    .any_o (rk2_any)
  );

  assign frame_edge = frame_clk & ~frame_q;
  assign snap_any   = (|NPC_Collision) | Ship_Collision | Ship_Collision2 |
                      (|Rocket_Collision) | (|Rocket_Collision2);
  assign xfer       = evt_valid_q & evt_ready;
  // Output register may be (re)loaded when empty or being consumed this cycle.
  assign slot_free  = ~evt_valid_q | evt_ready;

  always_comb begin
    state_d     = state_q;
    npc_d       = npc_q;
    rk1_d       = rk1_q;
    rk2_d       = rk2_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    cr1_d       = cr1_q;
    cr2_d       = cr2_q;
    evt_valid_d = evt_valid_q;
    evt_type_d  = evt_type_q;
    evt_index_d = evt_index_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    lives1_d    = lives1_q;
    lives2_d    = lives2_q;
    overrun_d   = overrun_q;

    if (state_q == ST_IDLE) begin
      if (frame_edge && snap_any) begin
        npc_d   = NPC_Collision;
        rk1_d   = Rocket_Collision;
        rk2_d   = Rocket_Collision2;
        s1_d    = Ship_Collision;
        s2_d    = Ship_Collision2;
        cr1_d   = |Rocket_Collision;
        cr2_d   = |Rocket_Collision2;
        state_d = ST_NPC;
      end
    end else begin
      // Includes the cycle of the final transfer: still busy, edge dropped.
      if (frame_edge) begin
        overrun_d = 1'b1;
      end

      if (xfer) begin
        case (evt_type_q)
          EVT_NPC_KILL: begin
            if (cr1_q) begin
              score1_d = sat_add16(score1_q, 16'(KILL_POINTS));
            end else if (cr2_q) begin
              score2_d = sat_add16(score2_q, 16'(KILL_POINTS));
            end
          end
          EVT_SHIP1_HIT: begin
            if (lives1_q != 2'd0) lives1_d = lives1_q - 2'd1;
          end
          EVT_SHIP2_HIT: begin
            if (lives2_q != 2'd0) lives2_d = lives2_q - 2'd1;
          end
          default: ;
        endcase
      end

      // Pending vectors drain in scan order, so a fixed priority across the
      // categories reproduces the state order and skips empty states for free.
      if (slot_free) begin
        evt_valid_d = 1'b1;
        evt_index_d = 4'd0;
        if (npc_any) begin
          evt_type_d  = EVT_NPC_KILL;
          evt_index_d = npc_idx;
          npc_d       = npc_q & (npc_q - NUM_NPC'(1));
          state_d     = ST_NPC;
        end else if (s1_q) begin
          evt_type_d  = EVT_SHIP1_HIT;
          s1_d        = 1'b0;
          state_d     = ST_SHIP1;
        end else if (s2_q) begin
          evt_type_d  = EVT_SHIP2_HIT;
          s2_d        = 1'b0;
          state_d     = ST_SHIP2;
        end else if (rk1_any) begin
          evt_type_d  = EVT_ROCKET1_CLR;
          evt_index_d = rk1_idx;
          rk1_d       = rk1_q & (rk1_q - NUM_ROCKET'(1));
          state_d     = ST_RKT1;
        end else if (rk2_any) begin
          evt_type_d  = EVT_ROCKET2_CLR;
          evt_index_d = rk2_idx;
          rk2_d       = rk2_q & (rk2_q - NUM_ROCKET'(1));
          state_d     = ST_RKT2;
        end else begin
          evt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      frame_q     <= 1'b0;
      npc_q       <= '0;
      rk1_q       <= '0;
      rk2_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      cr1_q       <= 1'b0;
      cr2_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_type_q  <= EVT_NPC_KILL;
      evt_index_q <= 4'd0;
      score1_q    <= 16'd0;
      score2_q    <= 16'd0;
      lives1_q    <= 2'(LIVES_INIT);
      lives2_q    <= 2'(LIVES_INIT);
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_clk;
      npc_q       <= npc_d;
      rk1_q       <= rk1_d;
      rk2_q       <= rk2_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cr1_q       <= cr1_d;
      cr2_q       <= cr2_d;
      evt_valid_q <= evt_valid_d;
      evt_type_q  <= evt_type_d;
      evt_index_q <= evt_index_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      lives1_q    <= lives1_d;
      lives2_q    <= lives2_d;
      overrun_q   <= overrun_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_type  = evt_type_q;
  assign evt_index = evt_index_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign lives1    = lives1_q;
  assign lives2    = lives2_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
  assign game_over = (lives1_q == 2'd0) & (lives2_q == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_collision_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_collision_event_scheduler
// Purpose : Self-checking bench for collision_event_scheduler. A frame-level
//           reference model expands each snapshot into its ordered event list
//           and tracks scores, lives and the overrun flag.
// Rev     : 1.0  initial release
// ============================================================================
module tb_collision_event_scheduler;

  logic        VGA_CLK = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic        Ship_Collision, Ship_Collision2;
  logic [14:0] Rocket_Collision, Rocket_Collision2;
  logic [9:0]  NPC_Collision;
  logic        evt_valid, evt_ready;
  logic [2:0]  evt_type;
  logic [3:0]  evt_index;
  logic [15:0] score1, score2;
  logic [1:0]  lives1, lives2;
  logic        busy, game_over, overrun;

  always #5 VGA_CLK = ~VGA_CLK;

  collision_event_scheduler dut (
    .VGA_CLK           (VGA_CLK),
    .Reset_n           (Reset_n),
    .frame_clk         (frame_clk),
    .Ship_Collision    (Ship_Collision),
    .Ship_Collision2   (Ship_Collision2),
    .Rocket_Collision  (Rocket_Collision),
    .Rocket_Collision2 (Rocket_Collision2),
    .NPC_Collision     (NPC_Collision),
    .evt_valid         (evt_valid),
    .evt_ready         (evt_ready),
    .evt_type          (evt_type),
    .evt_index         (evt_index),
    .score1            (score1),
    .score2            (score2),
    .lives1            (lives1),
    .lives2            (lives2),
    .busy              (busy),
    .game_over         (game_over),
    .overrun           (overrun)
  );

  typedef struct { int typ; int idx; } ev_t;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int m_s1, m_s2, m_l1, m_l2;
  bit m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int s);
    return (s + 10 > 65535) ? 65535 : s + 10;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_l1 = 3; m_l2 = 3; m_ovr = 0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_score1"},   score1,    m_s1);
    check_eq({tag, "_score2"},   score2,    m_s2);
    check_eq({tag, "_lives1"},   lives1,    m_l1);
    check_eq({tag, "_lives2"},   lives2,    m_l2);
    check_eq({tag, "_gameover"}, game_over, (m_l1 == 0 && m_l2 == 0) ? 1 : 0);
    check_eq({tag, "_overrun"},  overrun,   m_ovr);
  endtask

  task automatic clear_inputs();
    Ship_Collision = 0; Ship_Collision2 = 0;
    Rocket_Collision = '0; Rocket_Collision2 = '0; NPC_Collision = '0;
  endtask

  task automatic do_reset();
    @(negedge VGA_CLK);
    Reset_n = 0; frame_clk = 0; evt_ready = 0;
    clear_inputs();
    #1;
    model_reset();
    check_eq("rst_evt_valid", evt_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_status("rst");
    repeat (2) @(negedge VGA_CLK);
    Reset_n = 1;
  endtask

  // mode: 0 = ready always high, 1 = ready toggling, 2 = random ready
  task automatic run_frame(input logic [9:0] npc, input logic [14:0] r1, input logic [14:0] r2,
                           input bit s1, input bit s2, input int mode, input int ovr_pct,
                           input bit force_ovr, input int abort_after);
    ev_t q[$];
    ev_t e;
    bit  c1, c2, r, done, seen_valid, prev_stall, fc_prev;
    int  pops;
    for (int i = 0; i < 10; i++) if (npc[i]) q.push_back('{0, i});
    if (s1) q.push_back('{1, 0});
    if (s2) q.push_back('{2, 0});
    for (int i = 0; i < 15; i++) if (r1[i]) q.push_back('{3, i});
    for (int i = 0; i < 15; i++) if (r2[i]) q.push_back('{4, i});
    c1 = (r1 != 0); c2 = (r2 != 0);

    @(negedge VGA_CLK);
    NPC_Collision = npc; Rocket_Collision = r1; Rocket_Collision2 = r2;
    Ship_Collision = s1; Ship_Collision2 = s2;
    frame_clk = 1; evt_ready = 0;
    @(negedge VGA_CLK);
    frame_clk = 0;
    clear_inputs();

    pops = 0; done = 0; seen_valid = 0; prev_stall = 0; fc_prev = 0;
    for (int it = 0; it < 400 && !done; it++) begin
      if (q.size() == 0) begin
        check_eq("idle_busy", busy, 0);
        check_eq("idle_valid", evt_valid, 0);
        done = 1;
      end else if (abort_after >= 0 && pops == abort_after) begin
        #2 Reset_n = 0;
        #1;
        model_reset();
        q.delete();
        check_eq("abort_valid", evt_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_status("abort");
        @(negedge VGA_CLK);
        Reset_n = 1;
        done = 1;
      end else begin
        r = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(it % 2) : bit'($urandom_range(0, 1));
        if (prev_stall) check_eq("stall_hold", evt_valid, 1);
        if (mode == 0 && seen_valid) check_eq("back_to_back", evt_valid, 1);
        if (evt_valid) begin
          seen_valid = 1;
          check_eq("evt_type", evt_type, q[0].typ);
          check_eq("evt_index", evt_index, q[0].idx);
        end
        evt_ready = r;
        if (evt_valid && r) begin
          e = q.pop_front();
          pops++;
          case (e.typ)
            0: if (c1) m_s1 = sat(m_s1); else if (c2) m_s2 = sat(m_s2);
            1: if (m_l1 > 0) m_l1--;
            2: if (m_l2 > 0) m_l2--;
            default: ;
          endcase
        end
        prev_stall = evt_valid && !r;
        // Extra frame edge while the scheduler is busy: must be dropped.
        if (!fc_prev && ((force_ovr && it == 1) || $urandom_range(0, 99) < ovr_pct)) begin
          frame_clk = 1;
          NPC_Collision = 10'($urandom);
          Rocket_Collision = 15'($urandom);
          Ship_Collision = 1'($urandom);
          m_ovr = 1;
        end else begin
          frame_clk = 0;
          clear_inputs();
        end
        fc_prev = frame_clk;
        @(negedge VGA_CLK);
      end
    end
    check_eq("frame_done", done, 1);
    frame_clk = 0; evt_ready = 0;
    clear_inputs();
    check_status("frame");
  endtask

  initial begin
    Reset_n = 0; frame_clk = 0; evt_ready = 0;
    clear_inputs();
    do_reset();

    // NPC kills 0,2,5 credited to player 1, then rocket clear 0
    run_frame(10'b0000100101, 15'h0001, 15'h0000, 0, 0, 0, 0, 0, -1);
    check_eq("kill_score1_30", score1, 30);

    // Both ships hit, ready toggling: SHIP1 held across stalls, then SHIP2
    run_frame(10'b0, 15'h0, 15'h0, 1, 1, 1, 0, 0, -1);

    // Lives countdown to floor
    do_reset();
    for (int k = 0; k < 4; k++) run_frame(10'b0, 15'h0, 15'h0, 1, 0, 2, 0, 0, -1);
    check_eq("lives1_floor", lives1, 0);

    // Overrun: edge while busy is dropped, original events complete
    run_frame(10'b1010010011, 15'h0000, 15'h0102, 0, 1, 2, 0, 1, -1);

    // Reset mid-NPC scan, then a fresh scan of the next snapshot
    run_frame(10'b1111000011, 15'h0003, 15'h0000, 1, 0, 0, 0, 0, 2);
    run_frame(10'b0000010000, 15'h0000, 15'h0010, 0, 1, 2, 0, 0, -1);

    // Randomized frames, including empty snapshots and stray edges
    for (int k = 0; k < 60; k++) begin
      logic [9:0]  npc;
      logic [14:0] r1, r2;
      bit          s1, s2;
      npc = 10'($urandom & $urandom);
      r1  = ($urandom_range(0, 2) == 0) ? 15'($urandom & $urandom) : 15'h0;
      r2  = ($urandom_range(0, 2) == 0) ? 15'($urandom & $urandom) : 15'h0;
      s1  = ($urandom_range(0, 3) == 0);
      s2  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin npc = 0; r1 = 0; r2 = 0; s1 = 0; s2 = 0; end
      run_frame(npc, r1, r2, s1, s2, 2, 5, 0, -1);
    end

    // Saturation: 6560 credited kills pushes score1 past 16'hFFFF
    do_reset();
    for (int k = 0; k < 656; k++) run_frame(10'h3FF, 15'h0001, 15'h0000, 0, 0, 0, 0, 0, -1);
    check_eq("score1_saturated", score1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/collision_event_scheduler.md
COLLISION_EVENT_SCHEDULER -- requirements
Module: collision_event_scheduler

Interface
REQ-001 Parameter NUM_NPC, default 10, number of NPC collision bits.
REQ-002 Parameter NUM_ROCKET, default 15, rocket collision bits per player.
REQ-003 Parameter LIVES_INIT, default 3, lives per player after reset.
REQ-004 Parameter KILL_POINTS, default 10, score added per credited NPC kill.
REQ-005 One clock and one reset: reset is asynchronous and active-low.
REQ-006 VGA_CLK  in  1  sole clock.
REQ-007 Reset_n  in  1  asynchronous active-low reset.
REQ-008 frame_clk  in  1  frame strobe; its rising edge is sampled in the VGA_CLK domain.
REQ-009 Ship_Collision, Ship_Collision2  in  1 each  latched ship-hit flags from the collision detector.
REQ-010 Rocket_Collision, Rocket_Collision2  in  NUM_ROCKET each  latched rocket-hit vectors.
REQ-011 NPC_Collision  in  NUM_NPC  latched NPC-hit vector.
REQ-012 evt_valid  out  1; evt_ready  in  1: event handshake, transfer when both are high.
REQ-013 evt_type  out  3  event type: NPC_KILL, SHIP1_HIT, SHIP2_HIT, ROCKET1_CLR, ROCKET2_CLR.
REQ-014 evt_index  out  4  NPC or rocket index; 0 for ship events.
REQ-015 score1, score2  out  16  player scores; lives1, lives2  out  2  remaining lives.
REQ-016 busy  out  1; game_over  out  1; overrun  out  1  sticky dropped-frame flag.

Function
REQ-017 Frame edge: register frame_clk; edge = frame_clk & ~registered value.
- Snapshot all collision inputs on the edge cycle, before the detector clears them.
REQ-018 Snapshot is taken only in IDLE with any bit set; then busy=1 from the next cycle.
- An all-zero snapshot leaves the FSM in IDLE.
REQ-019 FSM states and order: IDLE -> NPC -> SHIP1 -> SHIP2 -> RKT1 -> RKT2 -> IDLE.
- A state whose snapshot bits are all clear is skipped in the same cycle, with no dead cycle.
REQ-020 In NPC, RKT1 and RKT2: evt_index = lowest set bit; each transfer clears that bit; the state exits when the vector is empty.
REQ-021 evt_valid, evt_type and evt_index are registered and held stable while evt_valid=1 and evt_ready=0.
- evt_ready=1 sustained gives one event per cycle.
REQ-022 NPC_KILL transfer credits score1 if the snapshot Rocket_Collision is nonzero.
- Otherwise it credits score2 if Rocket_Collision2 is nonzero; otherwise no credit (ship ram).
REQ-023 Score add is +KILL_POINTS, saturating at 16'hFFFF.
REQ-024 SHIP1_HIT transfer decrements lives1, floored at 0; SHIP2_HIT decrements lives2 likewise.
REQ-025 game_over = (lives1==0) & (lives2==0), combinational from the lives registers.
- Scheduling continues when game_over=1.
REQ-026 A frame edge while busy sets overrun (sticky until reset) and is dropped, with no merge.
REQ-027 A frame edge in the same cycle as the final transfer counts as busy and is dropped.

Reset
REQ-028 Reset_n low, asynchronously:
- FSM to IDLE; snapshot and frame_clk register to 0.
- evt_valid, evt_type, evt_index, busy and overrun to 0.
- score1 and score2 to 0; lives1 and lives2 to LIVES_INIT.
REQ-029 Reset mid-sequence discards pending events; the next frame edge after release starts a fresh scan.

Structure
REQ-030 Shared package galaga_pkg holds:
- the evt_type enum;
- NUM_NPC and NUM_ROCKET defaults;
- KILL_POINTS and LIVES_INIT.
REQ-031 One sub-module, lowest_set_idx: a parameterised priority encoder giving index and nonzero flag, instantiated for the NPC and rocket scans.

Verification
REQ-032 Edge with NPC_Collision=10'b0000100101, Rocket_Collision=15'h0001, evt_ready=1.
- Expect NPC_KILL 0, 2, 5, then ROCKET1_CLR 0, on consecutive cycles.
- Expect score1=30, then IDLE.
REQ-033 Edge with Ship_Collision=1, Ship_Collision2=1, evt_ready toggling 1/0.
- Expect SHIP1_HIT held across stalls, then SHIP2_HIT.
- Expect lives1=2 and lives2=2.
REQ-034 Four edges with Ship_Collision=1 each.
- Expect lives1 3->2->1->0->0; game_over=0 while lives2=3.
REQ-035 Score preset near saturation via 6554 NPC_KILL credits.
- Expect score1 to saturate at 16'hFFFF with no wrap.
REQ-036 Edge while busy with evt_ready=0.
- Expect overrun=1; the second snapshot is ignored and the original events complete.
REQ-037 Reset_n pulsed low mid-NPC scan.
- Expect evt_valid=0 immediately and scores/lives back to reset values.
- The next edge re-scans its own snapshot only.
